// File: rtl/mod_updown_counter.sv
// Parametrised modulo-N up/down counter with load/clear, wrap or saturate mode,
// a zero-latency cascade terminal count and registered wrap / at-limit flags.
module mod_updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULO   = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    input  logic             enable_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             wrap_o,
    output logic             at_limit_o
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             atLimit_q, atLimit_d;
    logic [WIDTH-1:0] loadClamped;
    logic             atTerminal;

    // Out-of-range load values are pulled to the top of the range so the count
    // can never leave 0..MODULO-1.
    assign loadClamped = ({1'b0, load_value_i} > {1'b0, MaxVal}) ? MaxVal : load_value_i;

    assign atTerminal = up_i ? (count_q == MaxVal) : (count_q == '0);

    assign tc_o = enable_i & ~reset_i & ~clear_i & ~load_i & atTerminal;

    always_comb begin
        count_d   = count_q;
        wrap_d    = 1'b0;
        atLimit_d = atLimit_q;
        if (clear_i) begin
            count_d   = '0;
            atLimit_d = 1'b0;
        end else if (load_i) begin
            count_d   = loadClamped;
            atLimit_d = 1'b0;
        end else if (enable_i) begin
            if (!atTerminal) begin
                count_d   = up_i ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
                atLimit_d = 1'b0;
            end else if (SATURATE) begin
                atLimit_d = 1'b1;
            end else begin
                count_d   = up_i ? '0 : MaxVal;
                wrap_d    = 1'b1;
                atLimit_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q   <= '0;
            wrap_q    <= 1'b0;
            atLimit_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            atLimit_q <= atLimit_d;
        end
    end

    assign count_o    = count_q;
    assign wrap_o     = wrap_q;
    assign at_limit_o = atLimit_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomised and directed bench for mod_updown_counter: three configurations share
// one stimulus stream against a behavioural model, plus a two-digit BCD cascade.
module tb_mod_updown_counter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] loadValue = '0;
    logic       enable = 1'b0;
    logic       up = 1'b1;

    logic [3:0] dCount [3];
    logic       dTc [3];
    logic       dWrap [3];
    logic       dLim [3];

    logic       casReset = 1'b1;
    logic       casEnable = 1'b0;
    logic [3:0] loCount, hiCount;
    logic       loTc, hiTc, loWrap, hiWrap, loLim, hiLim;

    int total = 0;
    int bad = 0;

    int modv [3] = '{16, 10, 10};
    bit satv [3] = '{1'b0, 1'b0, 1'b1};
    int mCount [3];
    bit mWrap [3];
    bit mLim [3];

    always #5 clock = ~clock;

    // Index 0: M16 wrap, index 1: M10 wrap, index 2: M10 saturate.
    for (genvar g = 0; g < 3; g++) begin : gDut
        mod_updown_counter #(
            .WIDTH(4), .MODULO(g == 0 ? 16 : 10), .SATURATE(g == 2)
        ) dut (
            .clock_i(clock), .reset_i(reset), .clear_i(clear), .load_i(load),
            .load_value_i(loadValue), .enable_i(enable), .up_i(up),
            .count_o(dCount[g]), .tc_o(dTc[g]), .wrap_o(dWrap[g]), .at_limit_o(dLim[g])
        );
    end

    mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) uLow (
        .clock_i(clock), .reset_i(casReset), .clear_i(1'b0), .load_i(1'b0),
        .load_value_i(4'd0), .enable_i(casEnable), .up_i(1'b1),
        .count_o(loCount), .tc_o(loTc), .wrap_o(loWrap), .at_limit_o(loLim)
    );

    mod_updown_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) uHigh (
        .clock_i(clock), .reset_i(casReset), .clear_i(1'b0), .load_i(1'b0),
        .load_value_i(4'd0), .enable_i(loTc), .up_i(1'b1),
        .count_o(hiCount), .tc_o(hiTc), .wrap_o(hiWrap), .at_limit_o(hiLim)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic int expTc(int i);
        int term;
        term = up ? modv[i] - 1 : 0;
        return (enable && !reset && !clear && !load && mCount[i] == term) ? 1 : 0;
    endfunction

    // Behavioural rules: modular arithmetic for wrap mode, min/max for saturate mode.
    function automatic void modelStep(int i);
        int c, m, nxt;
        c = mCount[i];
        m = modv[i];
        if (reset || clear) begin
            mCount[i] = 0; mWrap[i] = 1'b0; mLim[i] = 1'b0;
        end else if (load) begin
            mCount[i] = (int'(loadValue) > m - 1) ? m - 1 : int'(loadValue);
            mWrap[i] = 1'b0; mLim[i] = 1'b0;
        end else if (enable) begin
            if (satv[i]) begin
                nxt = up ? ((c + 1 > m - 1) ? m - 1 : c + 1) : ((c - 1 < 0) ? 0 : c - 1);
                mLim[i] = (nxt == c);
                mWrap[i] = 1'b0;
            end else begin
                nxt = up ? (c + 1) % m : (c + m - 1) % m;
                mWrap[i] = up ? (nxt < c) : (nxt > c);
                mLim[i] = 1'b0;
            end
            mCount[i] = nxt;
        end else begin
            mWrap[i] = 1'b0;
        end
    endfunction

    task automatic applyStimulus(input bit r, input bit c, input bit l, input int lv,
                                 input bit e, input bit u);
        @(negedge clock);
        reset = r; clear = c; load = l; loadValue = 4'(lv); enable = e; up = u;
        #1;
        for (int i = 0; i < 3; i++) checkOutput($sformatf("tc%0d", i), dTc[i], expTc(i));
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            modelStep(i);
            checkOutput($sformatf("count%0d", i), dCount[i], mCount[i]);
            checkOutput($sformatf("wrap%0d", i), dWrap[i], mWrap[i]);
            checkOutput($sformatf("atLimit%0d", i), dLim[i], mLim[i]);
        end
    endtask

    initial begin
        int satExp [5] = '{8, 9, 9, 9, 9};
        int limExp [5] = '{0, 0, 1, 1, 1};
        int hiWraps;

        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 0, 0, 0, 1);
        checkOutput("resetCount", dCount[0], 0);

        for (int k = 0; k < 20; k++) applyStimulus(0, 0, 0, 0, 1, 1);
        checkOutput("up20Count", dCount[0], 4);

        applyStimulus(1, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("downFrom0Count", dCount[1], 9);
        checkOutput("downFrom0Wrap", dWrap[1], 1);

        applyStimulus(0, 0, 1, 12, 0, 1);
        checkOutput("loadClampM10", dCount[1], 9);
        checkOutput("loadNoClampM16", dCount[0], 12);
        applyStimulus(0, 0, 1, 3, 1, 1);
        checkOutput("loadBeatsEnable", dCount[1], 3);

        applyStimulus(0, 0, 1, 7, 0, 1);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 0, 0, 1, 1);
            checkOutput($sformatf("satSeq%0d", k), dCount[2], satExp[k]);
            checkOutput($sformatf("satLim%0d", k), dLim[2], limExp[k]);
        end
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("satDownCount", dCount[2], 8);
        checkOutput("satDownLim", dLim[2], 0);

        applyStimulus(0, 0, 1, 5, 0, 1);
        applyStimulus(1, 1, 1, 6, 1, 1);
        checkOutput("prioAllCount", dCount[0], 0);
        applyStimulus(0, 0, 1, 5, 0, 1);
        applyStimulus(0, 1, 1, 6, 1, 1);
        checkOutput("prioClearLoad", dCount[0], 0);

        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 9) == 0) up = ~up;
            applyStimulus($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5,
                          $urandom_range(0, 99) < 8, int'($urandom_range(0, 15)),
                          $urandom_range(0, 99) < 75, up);
        end

        @(negedge clock);
        reset = 1'b1;
        casReset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        casReset = 1'b0;
        casEnable = 1'b1;
        hiWraps = 0;
        for (int n = 1; n <= 101; n++) begin
            @(posedge clock);
            #1;
            checkOutput($sformatf("bcd%0d", n), int'(hiCount) * 10 + int'(loCount), n % 100);
            checkOutput($sformatf("loTc%0d", n), loTc, (n % 10 == 9) ? 1 : 0);
            if (hiWrap) hiWraps++;
        end
        checkOutput("hiWrapCount", hiWraps, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
